// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths, boot-state encoding and NOOP word for the CPU memory controller
package cpu_mem_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] NOOP_WORD = 32'h0;

endpackage

// File: rtl/cpu_mem_ctrl_mem_array.sv
// mem_array_2r1w: DEPTH x DATA_W word array, two registered read ports, one write port, write-first bypass
module mem_array_2r1w #(
    parameter int          ADDR_W = 11,
    parameter int          DATA_W = 32,
    parameter int unsigned DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    import cpu_mem_pkg::*;

    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              w_ok;
    logic              a_ok;
    logic              b_ok;

    // addresses beyond the implemented words read as NOOP and never write
    assign w_ok = we && (32'(waddr) < DEPTH);
    assign a_ok = 32'(raddr_a) < DEPTH;
    assign b_ok = 32'(raddr_b) < DEPTH;

    // storage write; the array itself is not reset, the controller clears it
    always_ff @(posedge clk) begin
        if (w_ok)
            mem[waddr[IW-1:0]] <= wdata;
    end

    // registered read ports; a same-cycle write to the read address wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_a <= DATA_W'(NOOP_WORD);
            rdata_b <= DATA_W'(NOOP_WORD);
        end else begin
            if (re_a)
                rdata_a <= !a_ok ? DATA_W'(NOOP_WORD) :
                           (w_ok && waddr == raddr_a) ? wdata : mem[raddr_a[IW-1:0]];
            if (re_b)
                rdata_b <= !b_ok ? DATA_W'(NOOP_WORD) :
                           (w_ok && waddr == raddr_b) ? wdata : mem[raddr_b[IW-1:0]];
        end
    end

endmodule

// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: unified CPU word memory with clear/preload boot sequencing; CPU_MEM_WRITE_PROTECT_EN adds text-region store protection and wp_fault
module cpu_mem_ctrl #(
    parameter int          ADDR_W     = cpu_mem_pkg::ADDR_W,
    parameter int          DATA_W     = cpu_mem_pkg::DATA_W,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned TEXT_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_mem_ir,
    input  logic [ADDR_W-1:0] mem_radrs_ir,
    output logic [DATA_W-1:0] instruction_fetch,
    input  logic              read_mem_str,
    input  logic [ADDR_W-1:0] mem_radrs_ld,
    output logic [DATA_W-1:0] mem_store_data,
    input  logic              write_mem,
    input  logic [ADDR_W-1:0] mem_wadrs,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_adrs,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic              cpu_resetn,
    output logic              init_busy
`ifdef CPU_MEM_WRITE_PROTECT_EN
    ,
    output logic              wp_fault
`endif
);
    import cpu_mem_pkg::*;

`ifdef CPU_MEM_WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    state_t            state;
    logic [ADDR_W:0]   clr_cnt;
    logic              run;
    logic              last;
    logic              wp_hit;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign run    = state == RUN;
    assign last   = clr_cnt == (ADDR_W+1)'(DEPTH - 1);
    assign wp_hit = WP_EN && run && write_mem && (32'(mem_wadrs) < TEXT_LIMIT);

    // single write port shared by the clear sweep, host preload and CPU stores
    always_comb begin
        we    = state == CLEAR ? 1'b1 :
                state == LOAD  ? load_valid && load_ready :
                run && write_mem && !wp_hit;
        waddr = state == CLEAR ? clr_cnt[ADDR_W-1:0] :
                state == LOAD  ? load_adrs : mem_wadrs;
        wdata = state == CLEAR ? DATA_W'(NOOP_WORD) :
                state == LOAD  ? load_data : mem_wdata;
    end

    // boot sequencer CLEAR -> LOAD -> RUN with registered handshake and core-reset outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            cpu_resetn <= 1'b0;
            load_ready <= 1'b0;
            init_busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (last) begin
                        state      <= LOAD;
                        load_ready <= 1'b1;
                        init_busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_done) begin
                        state      <= RUN;
                        load_ready <= 1'b0;
                        cpu_resetn <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_MEM_WRITE_PROTECT_EN
    // sticky record of any store aimed at the text region
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wp_fault <= 1'b0;
        else if (wp_hit)
            wp_fault <= 1'b1;
    end
`endif

    mem_array_2r1w #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re_a    (run && read_mem_ir),
        .raddr_a (mem_radrs_ir),
        .rdata_a (instruction_fetch),
        .re_b    (run && read_mem_str),
        .raddr_b (mem_radrs_ld),
        .rdata_b (mem_store_data)
    );

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb_cpu_mem_ctrl: directed and randomized checks of cpu_mem_ctrl against a behavioural memory model
`timescale 1ns/1ps
module tb_cpu_mem_ctrl;

    localparam int DEPTH      = 2048;
    localparam int TEXT_LIMIT = 1024;
`ifdef CPU_MEM_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
    logic wp_fault;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        read_mem_ir;
    logic [10:0] mem_radrs_ir;
    logic [31:0] instruction_fetch;
    logic        read_mem_str;
    logic [10:0] mem_radrs_ld;
    logic [31:0] mem_store_data;
    logic        write_mem;
    logic [10:0] mem_wadrs;
    logic [31:0] mem_wdata;
    logic        load_valid;
    logic        load_ready;
    logic [10:0] load_adrs;
    logic [31:0] load_data;
    logic        load_done;
    logic        cpu_resetn;
    logic        init_busy;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_if;
    logic [31:0] exp_ld;
    logic        exp_wpf;
    logic        load_ph;
    logic        run_ph;
    logic [31:0] words [4];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    cpu_mem_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .read_mem_ir       (read_mem_ir),
        .mem_radrs_ir      (mem_radrs_ir),
        .instruction_fetch (instruction_fetch),
        .read_mem_str      (read_mem_str),
        .mem_radrs_ld      (mem_radrs_ld),
        .mem_store_data    (mem_store_data),
        .write_mem         (write_mem),
        .mem_wadrs         (mem_wadrs),
        .mem_wdata         (mem_wdata),
        .load_valid        (load_valid),
        .load_ready        (load_ready),
        .load_adrs         (load_adrs),
        .load_data         (load_data),
        .load_done         (load_done),
        .cpu_resetn        (cpu_resetn),
        .init_busy         (init_busy)
`ifdef CPU_MEM_WRITE_PROTECT_EN
        ,
        .wp_fault          (wp_fault)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        exp_if  = 32'h0;
        exp_ld  = 32'h0;
        exp_wpf = 1'b0;
        load_ph = 1'b0;
        run_ph  = 1'b0;
    endtask

    task automatic idle();
        read_mem_ir  = 1'b0;
        read_mem_str = 1'b0;
        write_mem    = 1'b0;
        mem_radrs_ir = '0;
        mem_radrs_ld = '0;
        mem_wadrs    = '0;
        mem_wdata    = '0;
    endtask

    // one clock; the model applies what the DUT saw at that edge
    task automatic tick();
        logic wr;
        @(posedge clk);
        #1;
        if (load_ph && load_valid) model[load_adrs] = load_data;
        if (run_ph) begin
            wr = write_mem && !(WP && int'(mem_wadrs) < TEXT_LIMIT);
            if (read_mem_ir)  exp_if = (wr && mem_wadrs == mem_radrs_ir) ? mem_wdata : model[mem_radrs_ir];
            if (read_mem_str) exp_ld = (wr && mem_wadrs == mem_radrs_ld) ? mem_wdata : model[mem_radrs_ld];
            if (wr) model[mem_wadrs] = mem_wdata;
            if (write_mem && !wr) exp_wpf = 1'b1;
        end
    endtask

    task automatic rd_if(input logic [10:0] a);
        read_mem_ir = 1'b1; mem_radrs_ir = a; tick(); read_mem_ir = 1'b0;
    endtask

    task automatic rd_ld(input logic [10:0] a);
        read_mem_str = 1'b1; mem_radrs_ld = a; tick(); read_mem_str = 1'b0;
    endtask

    task automatic clear_wait(input string tag);
        int n = 0;
        while (init_busy === 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, n, DEPTH);
        chk({tag, "_load_ready"}, load_ready, 1);
        chk({tag, "_cpu_resetn"}, cpu_resetn, 0);
        load_ph = 1'b1;
    endtask

    function automatic logic [10:0] pick();
        return ($urandom % 2 != 0) ? 11'(($urandom % 8) * 200) : 11'($urandom);
    endfunction

    task automatic rand_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            write_mem    = 1'($urandom);
            mem_wadrs    = pick();
            mem_wdata    = $urandom;
            read_mem_ir  = 1'($urandom);
            mem_radrs_ir = ($urandom % 4 == 0) ? mem_wadrs : pick();
            read_mem_str = 1'($urandom);
            mem_radrs_ld = ($urandom % 4 == 0) ? mem_wadrs : pick();
            tick();
            chk("rand_if", instruction_fetch, exp_if);
            chk("rand_ld", mem_store_data, exp_ld);
`ifdef CPU_MEM_WRITE_PROTECT_EN
            chk("rand_wpf", wp_fault, exp_wpf);
`endif
        end
        idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_if"}, instruction_fetch, 0);
        chk({tag, "_ld"}, mem_store_data, 0);
        chk({tag, "_resetn"}, cpu_resetn, 0);
        chk({tag, "_ready"}, load_ready, 0);
        chk({tag, "_busy"}, init_busy, 1);
`ifdef CPU_MEM_WRITE_PROTECT_EN
        chk({tag, "_wpf"}, wp_fault, 0);
`endif
    endtask

    initial begin
        words[0] = 32'h1111_0001;
        words[1] = 32'h2222_0002;
        words[2] = 32'hCAFE_F00D;
        words[3] = 32'h4444_0004;
        idle();
        load_valid = 1'b0;
        load_done  = 1'b0;
        load_adrs  = '0;
        load_data  = '0;
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;

        // empty image: clear, then load_done alone
        clear_wait("clear1_len");
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        load_ph = 1'b0;
        run_ph = 1'b1;
        chk("done_resetn", cpu_resetn, 1);
        chk("run_ready", load_ready, 0);
        rd_if(11'd0);    chk("clr_if_0", instruction_fetch, 0);
        rd_if(11'd1023); chk("clr_if_1023", instruction_fetch, 0);
        rd_ld(11'd2047); chk("clr_ld_2047", mem_store_data, 0);
        rand_run(300);

        // leave non-zero read outputs, then reset mid-RUN
        write_mem = 1'b1; mem_wadrs = 11'h7FF; mem_wdata = 32'hA5A5_A5A5;
        tick();
        idle();
        read_mem_ir = 1'b1; mem_radrs_ir = 11'h7FF;
        read_mem_str = 1'b1; mem_radrs_ld = 11'h7FF;
        tick();
        idle();
        chk("pre_rst_if", instruction_fetch, 32'hA5A5_A5A5);
        chk("pre_rst_ld", mem_store_data, 32'hA5A5_A5A5);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        clear_wait("clear2_len");

        // CPU traffic during LOAD is ignored
        write_mem = 1'b1; mem_wadrs = 11'd5; mem_wdata = 32'hFFFF_FFFF;
        read_mem_ir = 1'b1; mem_radrs_ir = 11'd5;
        read_mem_str = 1'b1; mem_radrs_ld = 11'h7FF;
        tick();
        idle();
        chk("load_quiet_if", instruction_fetch, 0);
        chk("load_quiet_ld", mem_store_data, 0);

        // back-to-back preload with load_done on the last beat
        for (int i = 0; i < 4; i++) begin
            chk("preload_ready", load_ready, 1);
            load_valid = 1'b1;
            load_adrs  = 11'(i);
            load_data  = words[i];
            load_done  = (i == 3);
            tick();
        end
        load_valid = 1'b0;
        load_done  = 1'b0;
        load_ph = 1'b0;
        run_ph = 1'b1;
        chk("boot_resetn", cpu_resetn, 1);
        chk("boot_ready", load_ready, 0);

        read_mem_ir = 1'b1; mem_radrs_ir = 11'd2;
        tick();
        read_mem_ir = 1'b0; mem_radrs_ir = 11'd3;
        chk("fetch2", instruction_fetch, words[2]);
        tick();
        chk("fetch_hold", instruction_fetch, words[2]);
        rd_if(11'd3);     chk("fetch3_last_beat", instruction_fetch, words[3]);
        rd_ld(11'd5);     chk("load_store_dropped", mem_store_data, 0);
        rd_ld(11'h7FF);   chk("recleared_7ff", mem_store_data, 0);

        // store then load
        write_mem = 1'b1; mem_wadrs = 11'h400; mem_wdata = 32'hDEAD_BEEF;
        tick();
        write_mem = 1'b0;
        rd_ld(11'h400);
        chk("store_load", mem_store_data, 32'hDEAD_BEEF);

        // write-first bypass on both ports at once
        write_mem = 1'b1; mem_wadrs = 11'h050; mem_wdata = 32'h1234_5678;
        read_mem_ir = 1'b1; mem_radrs_ir = 11'h050;
        read_mem_str = 1'b1; mem_radrs_ld = 11'h050;
        tick();
        idle();
        chk("bypass_if", instruction_fetch, WP ? 32'h0 : 32'h1234_5678);
        chk("bypass_ld", mem_store_data, WP ? 32'h0 : 32'h1234_5678);

        // text-region store
        write_mem = 1'b1; mem_wadrs = 11'h010; mem_wdata = 32'h1;
        tick();
        idle();
`ifdef CPU_MEM_WRITE_PROTECT_EN
        chk("wp_set", wp_fault, 1);
`endif
        rd_if(11'h010);
        chk("text_store", instruction_fetch, WP ? 32'h0 : 32'h1);
        tick();
`ifdef CPU_MEM_WRITE_PROTECT_EN
        chk("wp_sticky", wp_fault, 1);
`endif

        rand_run(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_ctrl.md
Name: cpu_mem_ctrl

Overview:
Unified word memory and boot controller that sits directly upstream of the pipelined CPU core. It supplies the CPU's instruction fetch and load-data read ports and accepts its store writes. Before the core runs, it clears the array and accepts a host program image, holding the core in reset until the host signals completion.

Parameters:
ADDR_W, 11, word address width; matches the CPU address ports.
DATA_W, 32, word width.
DEPTH, 2048, number of implemented words; must be <= 2**ADDR_W.
TEXT_LIMIT, 1024, first word address outside the text region; used only by the optional feature.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
read_mem_ir  in  1  instruction read enable from the CPU
mem_radrs_ir  in  ADDR_W  instruction read address
instruction_fetch  out  DATA_W  instruction word to the CPU
read_mem_str  in  1  load-data read enable from the CPU
mem_radrs_ld  in  ADDR_W  load-data read address
mem_store_data  out  DATA_W  load data to the CPU
write_mem  in  1  store write enable from the CPU
mem_wadrs  in  ADDR_W  store address
mem_wdata  in  DATA_W  store data
load_valid  in  1  host preload word valid
load_ready  out  1  controller accepts a preload word
load_adrs  in  ADDR_W  preload address
load_data  in  DATA_W  preload data
load_done  in  1  host program image complete
cpu_resetn  out  1  active-low reset to the CPU core
init_busy  out  1  high while the array is being cleared
wp_fault  out  1  sticky text-write violation; present only with the optional feature

Behaviour:
- Reset (asynchronous) values:
  - state = CLEAR, clear counter = 0.
  - instruction_fetch = 0, mem_store_data = 0.
  - cpu_resetn = 0, load_ready = 0, init_busy = 1, wp_fault = 0.
- State machine: CLEAR -> LOAD -> RUN. RUN is left only by reset, and reset mid-operation restarts at CLEAR.
- CLEAR:
  - Writes 0 to address counter each cycle; counter increments by 1.
  - When the counter reaches DEPTH-1, that word is written and the state moves to LOAD next cycle.
  - Duration is exactly DEPTH cycles.
  - init_busy = 1. All CPU ports are ignored and both read outputs are held at 0 (0 is NOOP).
- LOAD:
  - load_ready = 1 and init_busy = 0.
  - A word is written when load_valid && load_ready. Back-to-back words are allowed, one per cycle.
  - If load_done is seen in the same cycle as a valid word, the word is written first, then the state moves to RUN.
  - CPU ports are ignored; outputs are held at 0; cpu_resetn = 0.
- RUN:
  - cpu_resetn = 1 from the first RUN cycle; load_ready = 0; load_valid and load_done are ignored.
  - Reads: one-cycle registered latency. If read_mem_ir is high in cycle N, instruction_fetch shows mem[mem_radrs_ir] in cycle N+1. When the enable is low, the output holds its previous value. Same rule applies to read_mem_str / mem_store_data.
  - Both read ports may fire in the same cycle, including at the same address.
  - Write: mem[mem_wadrs] <= mem_wdata when write_mem is high.
  - Read-during-write to the same address is write-first: the read returns the new mem_wdata.
- Addresses >= DEPTH: reads return 0 and writes (preload or store) are dropped silently.
- All arithmetic is unsigned. The clear counter is ADDR_W+1 bits so that DEPTH = 2**ADDR_W cannot wrap early.

Optional Feature:
- Macro: CPU_MEM_WRITE_PROTECT_EN.
- Defined:
  - In RUN, any store with mem_wadrs < TEXT_LIMIT is dropped.
  - wp_fault goes high the following cycle and stays high until reset.
  - Preload writes are never protected.
- Not defined:
  - Stores are written anywhere below DEPTH.
  - The wp_fault port does not exist.

Decomposition:
- Shared package cpu_mem_pkg:
  - ADDR_W and DATA_W defaults.
  - State encoding typedef: CLEAR=2'd0, LOAD=2'd1, RUN=2'd2.
  - NOOP_WORD = 32'h0.
- Sub-module mem_array_2r1w: a DEPTH x DATA_W array with two registered read ports, one write port and write-first bypass.
- The FSM, clear counter, write-port mux (clear / preload / store) and protection logic live in the top level.

Test Plan:
- Clear check: assert reset for 2 cycles, release, preload nothing, pulse load_done. Expect init_busy high for exactly 2048 cycles, cpu_resetn rising one cycle after load_done, and reads at addresses 0, 1023 and 2047 returning 32'h0.
- Preload and fetch: preload words at addresses 0..3 back-to-back with load_done on the last beat. Then read_mem_ir with address 2 in cycle N. Expect instruction_fetch = the word preloaded at address 2 in cycle N+1, and the value held while read_mem_ir = 0.
- Store then load: in RUN, write_mem to address 11'h400 with 32'hDEADBEEF, then read_mem_str at 11'h400 the next cycle. Expect mem_store_data = 32'hDEADBEEF one cycle later.
- Write-first bypass and dual read: in one cycle, write 32'h12345678 to 11'h050 and read both ports at 11'h050. Expect both outputs = 32'h12345678 next cycle.
- Reset mid-RUN: assert reset during RUN. Expect all outputs at their reset values asynchronously, and CLEAR restarting with the counter at 0.
- Protection (macro defined): in RUN, store 32'h1 to 11'h010. Expect memory unchanged and wp_fault = 1 next cycle and held. Without the macro, the same stimulus writes 32'h1 to 11'h010.
